pipe_exec2mem_stage: RTL and testbench

//  Parametrised EXE->MEM pipeline stage with valid/ready flow control, a 2-entry skid buffer and synchronous flush.

---
 rtl/pipe_exec2mem_stage.sv | 123 ++++++++++++
 tb/tb_pipe_exec2mem_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_exec2mem_stage.sv
// EXE->MEM pipeline stage: valid/ready handshake, 2-entry skid buffer (main M, skid S), synchronous flush.
// Optional performance counters (stall_cnt, bubble_cnt) are built when EXE_MEM_PERF_EN is defined.
module pipe_exec2mem_stage #(
  parameter int               WIDTH     = 32,
  parameter int               PC_WIDTH  = WIDTH - 2,
  parameter logic [WIDTH-1:0] NOP_INSTR = {WIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    instruction_in,
  input  logic [PC_WIDTH-1:0] progcounter_in,
  input  logic [WIDTH-1:0]    dataC_in,
  input  logic [WIDTH-1:0]    addr_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    instruction_out,
  output logic [PC_WIDTH-1:0] progcounter_out,
  output logic [WIDTH-1:0]    dataC_out,
  output logic [WIDTH-1:0]    addr_out
`ifdef EXE_MEM_PERF_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         bubble_cnt
`endif
);

  localparam int EW = 3 * WIDTH + PC_WIDTH;

  logic          m_vld_q, m_vld_d;
  logic          s_vld_q, s_vld_d;
  logic [EW-1:0] m_ent_q, m_ent_d;
  logic [EW-1:0] s_ent_q, s_ent_d;
  logic [EW-1:0] in_ent;
  logic          accept;
  logic          drain;

  assign in_ent = {instruction_in, progcounter_in, dataC_in, addr_in};
  assign accept = in_valid & ~s_vld_q;
  assign drain  = m_vld_q & out_ready;

  // Ready depends only on held state, so the upstream never sees out_ready combinationally.
  always_comb begin
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    m_ent_d = m_ent_q;
    s_ent_d = s_ent_q;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!m_vld_q) begin
      if (accept) begin
        m_vld_d = 1'b1;
        m_ent_d = in_ent;
      end
    end else if (!s_vld_q) begin
      if (accept && drain) begin
        m_ent_d = in_ent;
      end else if (accept) begin
        s_vld_d = 1'b1;
        s_ent_d = in_ent;
      end else if (drain) begin
        m_vld_d = 1'b0;
      end
    end else if (drain) begin
      m_ent_d = s_ent_q;
      s_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      m_ent_q <= '0;
      s_ent_q <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      m_ent_q <= m_ent_d;
      s_ent_q <= s_ent_d;
    end
  end

  assign out_valid       = m_vld_q;
  assign in_ready        = ~s_vld_q;
  assign instruction_out = m_vld_q ? m_ent_q[EW-1 -: WIDTH] : NOP_INSTR;
  assign progcounter_out = m_ent_q[2*WIDTH +: PC_WIDTH];
  assign dataC_out       = m_ent_q[WIDTH +: WIDTH];
  assign addr_out        = m_ent_q[0 +: WIDTH];

`ifdef EXE_MEM_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (m_vld_q && !out_ready) stall_cnt_d = sat_inc(stall_cnt_q);
    if (!m_vld_q) bubble_cnt_d = sat_inc(bubble_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_exec2mem_stage.sv
// Bench for pipe_exec2mem_stage: reset, directed vector table, streaming, async reset, randomized run vs queue model.
// Counter checks are included when EXE_MEM_PERF_EN is defined.
module tb_pipe_exec2mem_stage;

  localparam int W  = 32;
  localparam int PW = W - 2;
  localparam logic [W-1:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [W-1:0]  instruction_in, dataC_in, addr_in;
  logic [PW-1:0] progcounter_in;
  logic [W-1:0]  instruction_out, dataC_out, addr_out;
  logic [PW-1:0] progcounter_out;
`ifdef EXE_MEM_PERF_EN
  logic [31:0]   stall_cnt, bubble_cnt;
`endif

  pipe_exec2mem_stage #(.WIDTH(W), .PC_WIDTH(PW), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction_in(instruction_in), .progcounter_in(progcounter_in),
    .dataC_in(dataC_in), .addr_in(addr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .instruction_out(instruction_out), .progcounter_out(progcounter_out),
    .dataC_out(dataC_out), .addr_out(addr_out)
`ifdef EXE_MEM_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0]  instr;
    logic [PW-1:0] pc;
    logic [W-1:0]  dc;
    logic [W-1:0]  ad;
  } ent_t;

  typedef struct {
    logic          f, iv, ordy;
    logic [PW-1:0] pc;
    logic          eov, eir;
    logic [PW-1:0] epc;
  } vec_t;

  vec_t tbl[16];
  ent_t q[$];

  function automatic logic [W-1:0] instr_of(input logic [PW-1:0] pc);
    return {pc, 2'b11} ^ 32'h5A00_0000;
  endfunction
  function automatic logic [W-1:0] dc_of(input logic [PW-1:0] pc);
    return 32'(pc) * 32'd7 + 32'd1;
  endfunction
  function automatic logic [W-1:0] ad_of(input logic [PW-1:0] pc);
    return {2'b10, pc};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic f, input logic iv, input logic ordy, input logic [PW-1:0] pc);
    flush          = f;
    in_valid       = iv;
    out_ready      = ordy;
    progcounter_in = pc;
    instruction_in = instr_of(pc);
    dataC_in       = dc_of(pc);
    addr_in        = ad_of(pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_entry(input string nm, input logic [PW-1:0] pc);
    chk({nm, " pc"}, 64'(progcounter_out), 64'(pc));
    chk({nm, " instr"}, 64'(instruction_out), 64'(instr_of(pc)));
    chk({nm, " dataC"}, 64'(dataC_out), 64'(dc_of(pc)));
    chk({nm, " addr"}, 64'(addr_out), 64'(ad_of(pc)));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
    chk({nm, " instr"}, 64'(instruction_out), 64'(NOP));
    chk({nm, " pc"}, 64'(progcounter_out), 64'd0);
    chk({nm, " dataC"}, 64'(dataC_out), 64'd0);
    chk({nm, " addr"}, 64'(addr_out), 64'd0);
  endtask

  initial begin
    // Directed table starting from EMPTY; expectations are the state after each clock edge.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 30'h20, 1'b1, 1'b1, 30'h20}; // A into M
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 30'h21, 1'b1, 1'b0, 30'h20}; // B into S, full
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 30'h22, 1'b1, 1'b0, 30'h20}; // refused, A held
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 30'h00, 1'b1, 1'b0, 30'h20};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 30'h00, 1'b1, 1'b0, 30'h20};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 30'h00, 1'b1, 1'b1, 30'h21}; // A drained, B moves up
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 30'h00, 1'b0, 1'b1, 30'h00}; // B drained
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 30'h30, 1'b1, 1'b1, 30'h30};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 30'h31, 1'b1, 1'b0, 30'h30};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 30'h32, 1'b0, 1'b1, 30'h00}; // flush in FULL with C offered
    tbl[10] = '{1'b0, 1'b0, 1'b1, 30'h00, 1'b0, 1'b1, 30'h00}; // C never appears
    tbl[11] = '{1'b0, 1'b1, 1'b1, 30'h40, 1'b1, 1'b1, 30'h40};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 30'h41, 1'b0, 1'b1, 30'h00}; // flush+accept+drain
    tbl[13] = '{1'b0, 1'b1, 1'b1, 30'h42, 1'b1, 1'b1, 30'h42}; // post-flush entry
    tbl[14] = '{1'b0, 1'b0, 1'b1, 30'h00, 1'b0, 1'b1, 30'h00};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 30'h50, 1'b0, 1'b1, 30'h00}; // flush from EMPTY discards accept

    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, '0);
    #1;
    chk_reset("reset");
    step();
    step();
    rst = 1'b0;

`ifdef EXE_MEM_PERF_EN
    chk("perf reset stall", 64'(stall_cnt), 64'd0);
    chk("perf reset bubble", 64'(bubble_cnt), 64'd0);
    step();
    set_in(1'b0, 1'b1, 1'b0, 30'h7);
    step();
    set_in(1'b0, 1'b0, 1'b0, '0);
    step();
    step();
    step();
    chk("perf stall", 64'(stall_cnt), 64'd3);
    chk("perf bubble", 64'(bubble_cnt), 64'd2);
    set_in(1'b1, 1'b0, 1'b1, '0);
    step();
    chk("perf stall after flush", 64'(stall_cnt), 64'd3);
    chk("perf bubble after flush", 64'(bubble_cnt), 64'd2);
    set_in(1'b0, 1'b0, 1'b0, '0);
`endif

    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].f, tbl[i].iv, tbl[i].ordy, tbl[i].pc);
      step();
      chk($sformatf("tbl[%0d] out_valid", i), 64'(out_valid), 64'(tbl[i].eov));
      chk($sformatf("tbl[%0d] in_ready", i), 64'(in_ready), 64'(tbl[i].eir));
      if (tbl[i].eov)
        chk_entry($sformatf("tbl[%0d]", i), tbl[i].epc);
      else
        chk($sformatf("tbl[%0d] nop", i), 64'(instruction_out), 64'(NOP));
    end

    // Streaming: each entry visible one cycle after it is offered.
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 1'b1, 1'b1, PW'(32'h10 + i));
      step();
      chk($sformatf("stream[%0d] out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("stream[%0d] in_ready", i), 64'(in_ready), 64'd1);
      chk_entry($sformatf("stream[%0d]", i), PW'(32'h10 + i));
    end
    set_in(1'b0, 1'b0, 1'b1, '0);
    step();
    chk("stream end out_valid", 64'(out_valid), 64'd0);

    // Async reset mid-cycle while FULL.
    set_in(1'b0, 1'b1, 1'b0, 30'h60);
    step();
    set_in(1'b0, 1'b1, 1'b0, 30'h61);
    step();
    chk("pre-reset in_ready", 64'(in_ready), 64'd0);
    #3;
    rst = 1'b1;
    #1;
    chk_reset("async reset");
    set_in(1'b0, 1'b0, 1'b1, '0);
    step();
    rst = 1'b0;
    step();
    chk("post-reset out_valid", 64'(out_valid), 64'd0);

    // Randomized run against a two-slot FIFO model.
    q.delete();
    for (int c = 0; c < 400; c++) begin
      ent_t e;
      logic acc, drn;
      flush          = ($urandom_range(0, 19) == 0);
      in_valid       = $urandom_range(0, 2) != 0;
      out_ready      = $urandom_range(0, 2) != 0;
      e.instr        = $urandom;
      e.pc           = PW'($urandom);
      e.dc           = $urandom;
      e.ad           = $urandom;
      instruction_in = e.instr;
      progcounter_in = e.pc;
      dataC_in       = e.dc;
      addr_in        = e.ad;
      acc = in_valid && (q.size() < 2);
      drn = out_ready && (q.size() > 0);
      step();
      if (flush) q.delete();
      else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      chk($sformatf("rnd[%0d] out_valid", c), 64'(out_valid), 64'(q.size() > 0));
      chk($sformatf("rnd[%0d] in_ready", c), 64'(in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
        chk($sformatf("rnd[%0d] instr", c), 64'(instruction_out), 64'(q[0].instr));
        chk($sformatf("rnd[%0d] pc", c), 64'(progcounter_out), 64'(q[0].pc));
        chk($sformatf("rnd[%0d] dataC", c), 64'(dataC_out), 64'(q[0].dc));
        chk($sformatf("rnd[%0d] addr", c), 64'(addr_out), 64'(q[0].ad));
      end else begin
        chk($sformatf("rnd[%0d] nop", c), 64'(instruction_out), 64'(NOP));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
